// File: rtl/square_draw_pkg.sv
// ---------------------------------------------------------------------------
// square_draw_pkg
// Shared types, sizes and helpers for the 4x4 square draw arbiter.
//   - state_t       : sequencer states (ERASE exists only with SQUARE_MOVE_EN)
//   - SQ_SIDE/SQ_PIXELS, X_W/Y_W/COL_W, COLOUR_BLACK, CNT_W/CNT_LAST
//   - sq_x/sq_y     : pixel coordinate for a given raster index within a square
// Optional feature macro: SQUARE_MOVE_EN
// ---------------------------------------------------------------------------
package square_draw_pkg;

  localparam int SQ_SIDE   = 4;
  localparam int SQ_PIXELS = 16;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COL_W     = 3;
  localparam int CNT_W     = 4;

  localparam logic [COL_W-1:0] COLOUR_BLACK = 3'b000;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SQ_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef SQUARE_MOVE_EN
    S_ERASE = 2'd1,
`endif
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Column offset is cnt[1:0]; the add wraps modulo 256 (no clipping).
  function automatic logic [X_W-1:0] sq_x(input logic [X_W-1:0] base,
                                          input logic [CNT_W-1:0] cnt);
    return base + {{(X_W-2){1'b0}}, cnt[1:0]};
  endfunction

  // Row offset is cnt[3:2]; the add wraps modulo 128 (no clipping).
  function automatic logic [Y_W-1:0] sq_y(input logic [Y_W-1:0] base,
                                          input logic [CNT_W-1:0] cnt);
    return base + {{(Y_W-2){1'b0}}, cnt[3:2]};
  endfunction

endpackage

// File: rtl/square_draw_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker: the winner is the first asserted request
// found searching upward from i_ptr, wrapping past NUM_REQ-1 to 0.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [IDX_W]    index with highest priority this round
//   o_win   [IDX_W]    winning index (0 when none)
//   o_valid            at least one request asserted
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_win,
  output logic               o_valid
);

  logic [IDX_W:0]   w_cand_sum [NUM_REQ];
  logic [IDX_W-1:0] w_cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand_req;

  // Candidate gi is the requester gi places above the pointer, taken mod NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign w_cand_sum[gi] = {1'b0, i_ptr} + (IDX_W+1)'(gi);
    assign w_cand_idx[gi] = (w_cand_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(w_cand_sum[gi] - (IDX_W+1)'(NUM_REQ))
                          : w_cand_sum[gi][IDX_W-1:0];
    assign w_cand_req[gi] = i_req[w_cand_idx[gi]];
  end

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        o_win   = w_cand_idx[k];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/square_draw_arbiter.sv
// ---------------------------------------------------------------------------
// square_draw_arbiter
// Shares one 4x4-square pixel-write path to the VGA adapter between NUM_REQ
// requesters. A round-robin winner's operands are latched, 16 pixels are
// issued in raster order, then a done pulse returns to the winner.
// Optional feature macro: SQUARE_MOVE_EN -- adds old-coordinate ports and
// erases the old square to black before drawing the new one.
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_req[N], i_req_x[N*8], i_req_y[N*7], i_req_colour[N*3]
//   i_req_old_x[N*8], i_req_old_y[N*7]   (SQUARE_MOVE_EN only)
//   o_grant[N], o_done[N]  one-hot single-cycle pulses
//   o_busy, o_x[8], o_y[7], o_colour[3], o_plot  (all registered)
// ---------------------------------------------------------------------------
module square_draw_arbiter
  import square_draw_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*X_W-1:0]   i_req_x,
  input  logic [NUM_REQ*Y_W-1:0]   i_req_y,
  input  logic [NUM_REQ*COL_W-1:0] i_req_colour,
`ifdef SQUARE_MOVE_EN
  input  logic [NUM_REQ*X_W-1:0]   i_req_old_x,
  input  logic [NUM_REQ*Y_W-1:0]   i_req_old_y,
`endif
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic                     o_busy,
  output logic [X_W-1:0]           o_x,
  output logic [Y_W-1:0]           o_y,
  output logic [COL_W-1:0]         o_colour,
  output logic                     o_plot
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Per-requester operand views of the packed input buses.
  logic [X_W-1:0]   w_req_x   [NUM_REQ];
  logic [Y_W-1:0]   w_req_y   [NUM_REQ];
  logic [COL_W-1:0] w_req_col [NUM_REQ];
`ifdef SQUARE_MOVE_EN
  logic [X_W-1:0]   w_req_ox  [NUM_REQ];
  logic [Y_W-1:0]   w_req_oy  [NUM_REQ];
`endif

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_x[gi]   = i_req_x[gi*X_W +: X_W];
    assign w_req_y[gi]   = i_req_y[gi*Y_W +: Y_W];
    assign w_req_col[gi] = i_req_colour[gi*COL_W +: COL_W];
`ifdef SQUARE_MOVE_EN
    assign w_req_ox[gi]  = i_req_old_x[gi*X_W +: X_W];
    assign w_req_oy[gi]  = i_req_old_y[gi*Y_W +: Y_W];
`endif
  end

  // State and latched operands.
  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [IDX_W-1:0] r_win, w_win_next;
  logic [X_W-1:0]   r_bx, w_bx_next;
  logic [Y_W-1:0]   r_by, w_by_next;
  logic [COL_W-1:0] r_col, w_col_next;
`ifdef SQUARE_MOVE_EN
  logic [X_W-1:0]   r_ox, w_ox_next;
  logic [Y_W-1:0]   r_oy, w_oy_next;
`endif

  // Output registers: next values are computed one cycle ahead so every
  // output comes straight from a flop.
  logic [NUM_REQ-1:0] r_grant, w_grant_next;
  logic [NUM_REQ-1:0] r_done, w_done_next;
  logic               r_busy, w_busy_next;
  logic [X_W-1:0]     r_x, w_x_next;
  logic [Y_W-1:0]     r_y, w_y_next;
  logic [COL_W-1:0]   r_colour, w_colour_next;
  logic               r_plot, w_plot_next;

  logic [IDX_W-1:0] w_win;
  logic             w_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_ptr_next    = r_ptr;
    w_win_next    = r_win;
    w_bx_next     = r_bx;
    w_by_next     = r_by;
    w_col_next    = r_col;
`ifdef SQUARE_MOVE_EN
    w_ox_next     = r_ox;
    w_oy_next     = r_oy;
`endif
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_colour_next = r_colour;
    w_plot_next   = 1'b0;
    w_grant_next  = '0;
    w_done_next   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_valid) begin
          w_win_next          = w_win;
          w_bx_next           = w_req_x[w_win];
          w_by_next           = w_req_y[w_win];
          w_col_next          = w_req_col[w_win];
          w_cnt_next          = '0;
          w_grant_next[w_win] = 1'b1;
          // First pixel (offset 0,0) goes out alongside the grant.
          w_plot_next         = 1'b1;
`ifdef SQUARE_MOVE_EN
          w_ox_next           = w_req_ox[w_win];
          w_oy_next           = w_req_oy[w_win];
          w_x_next            = w_req_ox[w_win];
          w_y_next            = w_req_oy[w_win];
          w_colour_next       = COLOUR_BLACK;
          w_state_next        = S_ERASE;
`else
          w_x_next            = w_req_x[w_win];
          w_y_next            = w_req_y[w_win];
          w_colour_next       = w_req_col[w_win];
          w_state_next        = S_DRAW;
`endif
        end
      end
`ifdef SQUARE_MOVE_EN
      S_ERASE: begin
        w_plot_next = 1'b1;
        if (r_cnt == CNT_LAST) begin
          // Erase finished: chain straight into the first draw pixel.
          w_cnt_next    = '0;
          w_x_next      = r_bx;
          w_y_next      = r_by;
          w_colour_next = r_col;
          w_state_next  = S_DRAW;
        end else begin
          w_cnt_next    = w_cnt_inc;
          w_x_next      = sq_x(r_ox, w_cnt_inc);
          w_y_next      = sq_y(r_oy, w_cnt_inc);
          w_colour_next = COLOUR_BLACK;
        end
      end
`endif
      S_DRAW: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next         = '0;
          w_done_next[r_win] = 1'b1;
          w_state_next       = S_DONE;
        end else begin
          w_cnt_next    = w_cnt_inc;
          w_plot_next   = 1'b1;
          w_x_next      = sq_x(r_bx, w_cnt_inc);
          w_y_next      = sq_y(r_by, w_cnt_inc);
          w_colour_next = r_col;
        end
      end
      S_DONE: begin
        // Next round starts searching just above this winner.
        w_ptr_next   = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_win    <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_col    <= '0;
`ifdef SQUARE_MOVE_EN
      r_ox     <= '0;
      r_oy     <= '0;
`endif
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ptr    <= w_ptr_next;
      r_win    <= w_win_next;
      r_bx     <= w_bx_next;
      r_by     <= w_by_next;
      r_col    <= w_col_next;
`ifdef SQUARE_MOVE_EN
      r_ox     <= w_ox_next;
      r_oy     <= w_oy_next;
`endif
      r_grant  <= w_grant_next;
      r_done   <= w_done_next;
      r_busy   <= w_busy_next;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_colour <= w_colour_next;
      r_plot   <= w_plot_next;
    end
  end

  assign o_grant  = r_grant;
  assign o_done   = r_done;
  assign o_busy   = r_busy;
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;
  assign o_plot   = r_plot;

endmodule

// File: tb/tb_square_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_square_draw_arbiter
// Directed plus randomized stimulus for square_draw_arbiter, checked against
// a reference model of the arbitration and pixel-sequence rules.
// Optional feature macro: SQUARE_MOVE_EN (must match the DUT build).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_square_draw_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_x;
  logic [N*7-1:0] req_y;
  logic [N*3-1:0] req_col;
`ifdef SQUARE_MOVE_EN
  logic [N*8-1:0] req_ox;
  logic [N*7-1:0] req_oy;
  localparam int PHASES = 2;
`else
  localparam int PHASES = 1;
`endif
  logic [N-1:0]   grant, done;
  logic           busy, plot;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  int txn      = 0;

  always #5 clk = ~clk;

  square_draw_arbiter #(.NUM_REQ(N)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_req        (req),
    .i_req_x      (req_x),
    .i_req_y      (req_y),
    .i_req_colour (req_col),
`ifdef SQUARE_MOVE_EN
    .i_req_old_x  (req_ox),
    .i_req_old_y  (req_oy),
`endif
    .o_grant      (grant),
    .o_done       (done),
    .o_busy       (busy),
    .o_x          (x),
    .o_y          (y),
    .o_colour     (colour),
    .o_plot       (plot)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first active requester at or above ptr, with wrap.
  function automatic int pick(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++)
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input int bx, input int by, input int col,
                         input int ox, input int oy);
    req_x[8*i +: 8]   = 8'(bx);
    req_y[7*i +: 7]   = 7'(by);
    req_col[3*i +: 3] = 3'(col);
`ifdef SQUARE_MOVE_EN
    req_ox[8*i +: 8]  = 8'(ox);
    req_oy[7*i +: 7]  = 7'(oy);
`else
    if (ox < 0 || oy < 0) $display("note: negative old coordinate ignored");
`endif
  endtask

  task automatic scramble_all();
    for (int i = 0; i < N; i++)
      set_req(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
              $urandom_range(0, 255), $urandom_range(0, 127));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_done"},  32'(done),  0);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_plot"},  32'(plot),  0);
  endtask

  // Called during an IDLE cycle with req already driven; runs one complete
  // square and leaves the bench in the following IDLE cycle.
  task automatic run_square(input bit drop_after_grant);
    int w, bx, by, col, ox, oy, px, py, pc;
    w = pick(req, m_ptr);
    if (w < 0) begin
      chk("no_requester", 0, 1);
      return;
    end
    bx  = int'(req_x[8*w +: 8]);
    by  = int'(req_y[7*w +: 7]);
    col = int'(req_col[3*w +: 3]);
`ifdef SQUARE_MOVE_EN
    ox  = int'(req_ox[8*w +: 8]);
    oy  = int'(req_oy[7*w +: 7]);
`else
    ox  = 0;
    oy  = 0;
`endif
    tick();
    chk("grant", 32'(grant), 32'(1 << w));
    // Operands are latched: further input changes must not matter.
    scramble_all();
    if (drop_after_grant) req[w] = 1'b0;
    for (int ph = 0; ph < PHASES; ph++) begin
      for (int p = 0; p < 16; p++) begin
        if (ph > 0 || p > 0) begin
          tick();
          chk("grant_low", 32'(grant), 0);
        end
        if (ph == 0 && PHASES == 2) begin
          px = (ox + p % 4) % 256;
          py = (oy + p / 4) % 128;
          pc = 0;
        end else begin
          px = (bx + p % 4) % 256;
          py = (by + p / 4) % 128;
          pc = col;
        end
        chk("plot",   32'(plot),   1);
        chk("x",      32'(x),      32'(px));
        chk("y",      32'(y),      32'(py));
        chk("colour", 32'(colour), 32'(pc));
        chk("busy",   32'(busy),   1);
        chk("done_early", 32'(done), 0);
      end
    end
    tick();
    chk("done",      32'(done), 32'(1 << w));
    chk("done_plot", 32'(plot), 0);
    chk("done_busy", 32'(busy), 1);
    tick();
    check_idle("after");
    m_ptr = (w + 1) % N;
    txn++;
    $display("txn %0d: winner=%0d base=(%0d,%0d) colour=%0d old=(%0d,%0d) drop=%0d checks=%0d",
             txn, w, bx, by, col, ox, oy, drop_after_grant, checks);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_x = '0;
    req_y = '0;
    req_col = '0;
`ifdef SQUARE_MOVE_EN
    req_oy = '0;
    req_ox = '0;
`endif
    #1;
    check_idle("reset");
    chk("reset_x", 32'(x), 0);
    chk("reset_y", 32'(y), 0);
    chk("reset_colour", 32'(colour), 0);
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    tick();
    check_idle("idle_noreq");
    tick();
    check_idle("idle_noreq2");

    // Basic square from requester 0.
    set_req(0, 10, 20, 3'b100, 9, 20);
    req = 4'b0001;
    run_square(1'b0);

    // Held requests from all four: strict rotation, 18-cycle spacing.
    rst = 1'b1;
    #1;
    check_idle("reset2");
    tick();
    rst = 1'b0;
    m_ptr = 0;
    scramble_all();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) run_square(1'b0);

    // Coordinate wrap at the screen edges.
    req = 4'b1000;
    set_req(3, 254, 126, 3'b011, 253, 125);
    run_square(1'b0);

    // Requester changes operands and drops req right after its grant.
    req = 4'b0100;
    set_req(2, 40, 50, 3'b110, 41, 51);
    run_square(1'b1);

    // Reset during cycle 8 of a square: outputs clear at once, no done.
    req = 4'b0001;
    set_req(0, 100, 60, 3'b001, 99, 61);
    tick();
    chk("abort_grant", 32'(grant), 32'b0001);
    for (int c = 2; c <= 8; c++) tick();
    rst = 1'b1;
    #1;
    check_idle("abort");
    req = 4'b0010;
    set_req(1, 70, 30, 3'b101, 72, 33);
    tick();
    check_idle("abort_hold");
    rst = 1'b0;
    m_ptr = 0;
    run_square(1'b0);

`ifdef SQUARE_MOVE_EN
    req = 4'b0001;
    set_req(0, 6, 5, 3'b010, 5, 5);
    run_square(1'b0);
`endif

    // Randomized mix of request masks, operands and early drops.
    for (int t = 0; t < 20; t++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(0, (1 << N) - 1));
      scramble_all();
      req = m;
      if (m == '0) begin
        tick();
        check_idle("rand_idle");
        tick();
        check_idle("rand_idle2");
      end else begin
        run_square(1'($urandom_range(0, 1)));
      end
    end

    req = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
